// File: rtl/snn_addr_gen.sv
// snn_addr_gen: multi-channel address generator for the SNN neuron/synapse memories.
// Each channel has its own base, inclusive limit, stride and wrap/stop mode.
// The selected channel's pointer is muxed combinationally onto addr.
module snn_addr_gen #(
    parameter int unsigned  DEPTH    = 8192,
    parameter int unsigned  CHANNELS = 4,
    localparam int unsigned AW       = $clog2(DEPTH + 1),
    localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [CW-1:0] ch_sel,
    input  logic          start,
    input  logic          inc,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_limit,
    input  logic [AW-1:0] cfg_stride,
    input  logic          cfg_wrap,
    output logic [AW-1:0] addr,
    output logic          active,
    output logic          last,
    output logic          wrap_p,
    output logic          done_p
);

    localparam logic [AW-1:0] LIMIT_RST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] STRIDE_RST = AW'(1);

    // Per-channel configuration and run state
    logic [AW-1:0] base_q   [CHANNELS];
    logic [AW-1:0] base_d   [CHANNELS];
    logic [AW-1:0] limit_q  [CHANNELS];
    logic [AW-1:0] limit_d  [CHANNELS];
    logic [AW-1:0] stride_q [CHANNELS];
    logic [AW-1:0] stride_d [CHANNELS];
    logic          wrap_q   [CHANNELS];
    logic          wrap_d   [CHANNELS];
    logic [AW-1:0] ptr_q    [CHANNELS];
    logic [AW-1:0] ptr_d    [CHANNELS];
    logic          active_q [CHANNELS];
    logic          active_d [CHANNELS];

    logic          wrap_p_q, wrap_p_d;
    logic          done_p_q, done_p_d;

    // Per-channel next pointer, one bit wider so overflow shows up as an end condition
    logic [AW:0]   nxt_c    [CHANNELS];
    logic          end_c    [CHANNELS];

    // Next pointer and end-of-range detection for every channel
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            nxt_c[c] = {1'b0, ptr_q[c]}
                     + {1'b0, ((stride_q[c] == '0) ? STRIDE_RST : stride_q[c])};
            end_c[c] = (nxt_c[c] > {1'b0, limit_q[c]});
        end
    end

    // Per-channel update: clr, then cfg_we, then start, then inc
    always_comb begin
        wrap_p_d = 1'b0;
        done_p_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            base_d[c]   = base_q[c];
            limit_d[c]  = limit_q[c];
            stride_d[c] = stride_q[c];
            wrap_d[c]   = wrap_q[c];
            ptr_d[c]    = ptr_q[c];
            active_d[c] = active_q[c];
            if (clr) begin
                ptr_d[c]    = base_q[c];
                active_d[c] = 1'b0;
            end else if (cfg_we && (cfg_ch == CW'(c))) begin
                base_d[c]   = cfg_base;
                limit_d[c]  = cfg_limit;
                stride_d[c] = cfg_stride;
                wrap_d[c]   = cfg_wrap;
                ptr_d[c]    = cfg_base;
                active_d[c] = 1'b0;
            end else if (start && (ch_sel == CW'(c))) begin
                ptr_d[c]    = base_q[c];
                active_d[c] = 1'b1;
            end else if (inc && (ch_sel == CW'(c)) && active_q[c]) begin
                if (!end_c[c]) begin
                    ptr_d[c] = nxt_c[c][AW-1:0];
                end else if (wrap_q[c]) begin
                    ptr_d[c] = base_q[c];
                    wrap_p_d = 1'b1;
                end else begin
                    active_d[c] = 1'b0;
                    done_p_d    = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                base_q[c]   <= '0;
                limit_q[c]  <= LIMIT_RST;
                stride_q[c] <= STRIDE_RST;
                wrap_q[c]   <= 1'b0;
                ptr_q[c]    <= '0;
                active_q[c] <= 1'b0;
            end
            wrap_p_q <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                base_q[c]   <= base_d[c];
                limit_q[c]  <= limit_d[c];
                stride_q[c] <= stride_d[c];
                wrap_q[c]   <= wrap_d[c];
                ptr_q[c]    <= ptr_d[c];
                active_q[c] <= active_d[c];
            end
            wrap_p_q <= wrap_p_d;
            done_p_q <= done_p_d;
        end
    end

    // Output mux of the selected channel; an out-of-range ch_sel reads as idle
    always_comb begin
        addr   = '0;
        active = 1'b0;
        last   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == CW'(c)) begin
                addr   = ptr_q[c];
                active = active_q[c];
                last   = active_q[c] & end_c[c];
            end
        end
    end

    assign wrap_p = wrap_p_q;
    assign done_p = done_p_q;

endmodule
